turfio_cmd_arbiter: RTL and testbench
=====================================

TURFIO_CMD_ARBITER -- requirements
Module: turfio_cmd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NREQ, 3, number of command requesters (2..8).
  TIMEOUT_CYCLES, 1023, cycles a granted command may stay unacknowledged (1..65535).
  CLKTYPE, "NONE", clock-domain tag for cross-clock attributes on the registered outputs.
REQ-002 Ports SHALL be, one per line:
  clk_i  input  1  sole clock; all logic on its rising edge.
  rst_i  input  1  asynchronous, active-high reset.
  req_pending_i  input  NREQ  per-requester command pending.
  req_dat_i  input  32*NREQ  per-requester command word; slice k is [32*k +: 32].
  req_ack_o  output  NREQ  per-requester one-cycle acknowledge.
  cmd_pending_o  output  1  command pending toward the TURFIO command link.
  cmd_dat_o  output  32  command word toward the link.
  cmd_ack_i  input  1  link acknowledge.
  grant_o  output  NREQ  one-hot current grant; zero when no grant.
  busy_o  output  1  high in any state other than IDLE.
  timeout_o  output  1  one-cycle pulse on an abandoned command.
  timeout_count_o  output  16  saturating count of timeouts.

Function
REQ-003 The FSM SHALL have the states IDLE, GRANT, ACK and ABORT.
REQ-004 IDLE: if any req_pending_i bit is high, the block SHALL select the winner round-robin, starting at (last_grant+1) mod NREQ, and enter GRANT on the next edge.
REQ-005 On entering GRANT, the block SHALL latch the winner's req_dat_i slice into cmd_dat_o; cmd_dat_o SHALL stay constant until the next grant.
REQ-006 cmd_pending_o SHALL be high exactly while in GRANT, and grant_o SHALL be one-hot while in GRANT, ACK or ABORT.
REQ-007 GRANT: when cmd_ack_i is high, the block SHALL go to ACK, and last_grant SHALL be updated to the winner.
REQ-008 ACK: req_ack_o[winner] SHALL be high for exactly one cycle; the next state SHALL be IDLE.
REQ-009 Latency: a request sampled in IDLE at cycle t SHALL give cmd_pending_o high at t+1.
  - An ack at cycle t SHALL give req_ack_o at t+1 and IDLE at t+2.
  - The earliest next cmd_pending_o SHALL be at t+3.
REQ-010 A wait counter SHALL clear on entering GRANT and increment each GRANT cycle without an ack.
  - When the counter equals TIMEOUT_CYCLES-1 and cmd_ack_i is low, the block SHALL go to ABORT.
REQ-011 ABORT: the block SHALL pulse timeout_o and req_ack_o[winner] for one cycle, increment timeout_count_o (saturating at 16'hFFFF), update last_grant, and return to IDLE.
REQ-012 Boundary and simultaneous events:
  - cmd_ack_i in the same cycle the timeout is reached SHALL be treated as a normal ack, with no timeout.
  - cmd_ack_i outside GRANT SHALL be ignored.
  - A requester dropping req_pending_i while granted SHALL NOT change the latched data or the state sequence.
REQ-013 At most one req_ack_o bit SHALL be high in any cycle; req_ack_o SHALL be zero in IDLE and GRANT.
REQ-014 With all requesters continuously pending, grants SHALL rotate 0,1,..,NREQ-1,0 with no requester starved.

Reset
REQ-015 rst_i high SHALL asynchronously force the following, and this SHALL hold even mid-GRANT:
  - state IDLE; cmd_pending_o=0, cmd_dat_o=0, grant_o=0, req_ack_o=0;
  - busy_o=0, timeout_o=0, timeout_count_o=0;
  - wait counter 0; last_grant=NREQ-1, so requester 0 wins first.
REQ-016 After rst_i deasserts, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-017 The state enum, the command width (32) and the timeout-counter width (16) SHALL live in package turfio_cmd_pkg.
REQ-018 Round-robin selection SHALL be one combinational sub-module, rr_priority_encoder.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot winner and a valid flag.

Verification
REQ-019 Single request: req_pending_i=3'b001 with dat 32'h8080_8080 at t0, cmd_ack_i at t0+4 -> cmd_pending_o high t0+1..t0+4, cmd_dat_o=32'h8080_8080, req_ack_o=3'b001 at t0+5 only.
REQ-020 Contention: all three pending from reset, each acked 2 cycles after its grant -> grant order 0,1,2,0; each grant is separated by 3 cycles after its ack.
REQ-021 Timeout: TIMEOUT_CYCLES=8, request 1 and no ack -> cmd_pending_o high 8 cycles, then timeout_o and req_ack_o=3'b010 together for 1 cycle, timeout_count_o=1.
REQ-022 Coincident ack and timeout: TIMEOUT_CYCLES=8, ack in the 8th GRANT cycle -> ACK path taken, timeout_o stays 0, timeout_count_o unchanged.
REQ-023 Reset mid-GRANT: assert rst_i 2 cycles into a grant of requester 2 -> all outputs 0 immediately; after release, with 3'b110 pending, requester 1 wins first.
REQ-024 Stray ack: cmd_ack_i pulsed in IDLE with no requests -> no state change, req_ack_o stays 0.

Source files
------------

// File: rtl/turfio_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turfio_cmd_pkg
// Brief    : Shared types and widths for the TURFIO command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package turfio_cmd_pkg;

    // Width of one command word toward the TURFIO link.
    localparam int CMD_W   = 32;
    // Width of the saturating timeout counter.
    localparam int TOCNT_W = 16;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2,
        ABORT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_encoder
// Brief    : Combinational round-robin picker. Searches the request vector
//            starting one position after last_grant (wrapping) and returns
//            the first pending requester as a one-hot winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_encoder #(
    parameter int NREQ = 3,
    parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LGW-1:0]  last_grant,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    // One extra bit so last_grant + offset never overflows before wrapping.
    localparam int SW = LGW + 1;

    logic [SW-1:0]  sum;
    logic [LGW-1:0] idx;

    // Walk offsets 1..NREQ from last_grant; the first pending index wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = {1'b0, last_grant} + SW'(off);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[LGW-1:0];
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/turfio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : turfio_cmd_arbiter
// Brief    : Round-robin arbiter feeding a single TURFIO command link from
//            NREQ requesters, with per-grant acknowledge timeout and a
//            saturating count of abandoned commands.
// Revision : 1.0 - initial release
// ============================================================================
module turfio_cmd_arbiter
    import turfio_cmd_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter     CLKTYPE        = "NONE"
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_pending_i,
    input  logic [CMD_W*NREQ-1:0]  req_dat_i,
    output logic [NREQ-1:0]        req_ack_o,
    output logic                   cmd_pending_o,
    output logic [CMD_W-1:0]       cmd_dat_o,
    input  logic                   cmd_ack_i,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [TOCNT_W-1:0]     timeout_count_o
);

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                 state;
    state_t                 state_nx;
    logic [LGW-1:0]         last_grant;
    logic [LGW-1:0]         grant_idx;
    logic [TOCNT_W-1:0]     wait_cnt;
    logic                   timeout_hit;
    logic                   armed;
    logic [NREQ-1:0]        win;
    logic                   win_vld;
    logic [CMD_W-1:0]       win_dat;

    (* CUSTOM_CC_SRC = CLKTYPE *) logic [NREQ-1:0]    grant_r;
    (* CUSTOM_CC_SRC = CLKTYPE *) logic [CMD_W-1:0]   cmd_dat_r;
    (* CUSTOM_CC_SRC = CLKTYPE *) logic [TOCNT_W-1:0] to_cnt_r;

    rr_priority_encoder #(
        .NREQ (NREQ),
        .LGW  (LGW)
    ) u_rr (
        .req        (req_pending_i),
        .last_grant (last_grant),
        .winner     (win),
        .valid      (win_vld)
    );

    // OR-mux of the winning requester's command word (winner is one-hot).
    always_comb begin
        win_dat = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win[k]) begin
                win_dat = win_dat | req_dat_i[CMD_W*k +: CMD_W];
            end
        end
    end

    // Index of the current grant, used to advance the round-robin pointer.
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_r[k]) begin
                grant_idx = LGW'(k);
            end
        end
    end

    assign timeout_hit = (wait_cnt == TOCNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic; an ack always beats a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (armed && win_vld) state_nx = GRANT;
            GRANT: begin
                if (cmd_ack_i)        state_nx = ACK;
                else if (timeout_hit) state_nx = ABORT;
            end
            ACK:     state_nx = IDLE;
            ABORT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Grant, command latch, wait counter, round-robin pointer and timeout count.
    // 'armed' holds off the first grant until one full edge after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed      <= 1'b0;
            grant_r    <= '0;
            cmd_dat_r  <= '0;
            wait_cnt   <= '0;
            last_grant <= LGW'(NREQ - 1);
            to_cnt_r   <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (state_nx == GRANT) begin
                        grant_r   <= win;
                        cmd_dat_r <= win_dat;
                        wait_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!cmd_ack_i) begin
                        wait_cnt <= wait_cnt + TOCNT_W'(1);
                    end
                    if (state_nx != GRANT) begin
                        last_grant <= grant_idx;
                    end
                    if (state_nx == ABORT && to_cnt_r != '1) begin
                        to_cnt_r <= to_cnt_r + TOCNT_W'(1);
                    end
                end
                ACK, ABORT: begin
                    grant_r <= '0;
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign cmd_pending_o   = (state == GRANT);
    assign busy_o          = (state != IDLE);
    assign timeout_o       = (state == ABORT);
    assign req_ack_o       = (state == ACK || state == ABORT) ? grant_r : '0;
    assign grant_o         = grant_r;
    assign cmd_dat_o       = cmd_dat_r;
    assign timeout_count_o = to_cnt_r;

endmodule
`default_nettype wire

// File: tb/tb_turfio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_turfio_cmd_arbiter
// Brief    : Directed self-checking bench for turfio_cmd_arbiter (NREQ=3,
//            TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_turfio_cmd_arbiter;

    localparam int NREQ = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  req_pending;
    logic [95:0] req_dat;
    logic [2:0]  req_ack;
    logic        cmd_pending;
    logic [31:0] cmd_dat;
    logic        cmd_ack;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout;
    logic [15:0] timeout_count;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_g;

    turfio_cmd_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (8),
        .CLKTYPE        ("NONE")
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_pending_i   (req_pending),
        .req_dat_i       (req_dat),
        .req_ack_o       (req_ack),
        .cmd_pending_o   (cmd_pending),
        .cmd_dat_o       (cmd_dat),
        .cmd_ack_i       (cmd_ack),
        .grant_o         (grant),
        .busy_o          (busy),
        .timeout_o       (timeout),
        .timeout_count_o (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cmd_ack     = 1'b0;
        req_pending = 3'b111;
        req_dat     = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        step();
        step();

        // Reset state.
        check("rst_pend",  32'(cmd_pending),   32'd0);
        check("rst_dat",   cmd_dat,            32'd0);
        check("rst_grant", 32'(grant),         32'd0);
        check("rst_ack",   32'(req_ack),       32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_to",    32'(timeout),       32'd0);
        check("rst_tcnt",  32'(timeout_count), 32'd0);

        // Contention: no grant on the first edge after release.
        rst = 1'b0;
        step();
        check("arm_busy",  32'(busy),  32'd0);
        check("arm_grant", 32'(grant), 32'd0);
        step();

        // Grants rotate 0,1,2,0; each acked 2 cycles after grant, next grant ack+3.
        for (int n = 0; n < 4; n++) begin
            exp_g = 3'b001 << (n % 3);
            check("rr_grant", 32'(grant),       32'(exp_g));
            check("rr_pend",  32'(cmd_pending), 32'd1);
            check("rr_dat",   cmd_dat,          32'hA000_0000 + 32'(n % 3));
            step();
            step();
            check("rr_noack", 32'(req_ack), 32'd0);
            cmd_ack = 1'b1;
            step();
            cmd_ack = 1'b0;
            check("rr_ack",     32'(req_ack),     32'(exp_g));
            check("rr_ackpend", 32'(cmd_pending), 32'd0);
            step();
            check("rr_idle", 32'(busy), 32'd0);
            step();
        end
        // Fifth grant goes to requester 1; finish it and go quiet.
        check("rr_fifth", 32'(grant), 32'b010);
        req_pending = 3'b000;
        cmd_ack     = 1'b1;
        step();
        cmd_ack = 1'b0;
        step();
        check("rr_quiet", 32'(busy), 32'd0);

        // Single request, ack at t0+4, requester drops pending while granted.
        req_pending   = 3'b001;
        req_dat[31:0] = 32'h8080_8080;
        step();
        check("single_pend",  32'(cmd_pending), 32'd1);
        check("single_dat",   cmd_dat,          32'h8080_8080);
        check("single_grant", 32'(grant),       32'b001);
        req_pending = 3'b000;
        req_dat     = '0;
        step();
        check("single_pend2", 32'(cmd_pending), 32'd1);
        step();
        check("single_pend3", 32'(cmd_pending), 32'd1);
        step();
        check("single_pend4", 32'(cmd_pending), 32'd1);
        check("drop_dat",     cmd_dat,          32'h8080_8080);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        check("single_ack",  32'(req_ack),     32'b001);
        check("single_pend5", 32'(cmd_pending), 32'd0);
        step();
        check("single_ack_off", 32'(req_ack), 32'd0);
        check("single_idle",    32'(busy),    32'd0);
        step();

        // Stray ack in IDLE is ignored.
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        check("stray_busy", 32'(busy),        32'd0);
        check("stray_ack",  32'(req_ack),     32'd0);
        check("stray_pend", 32'(cmd_pending), 32'd0);
        step();

        // Timeout: requester 1, never acked, 8 GRANT cycles then ABORT.
        req_pending    = 3'b010;
        req_dat[63:32] = 32'hC0DE_0001;
        step();
        req_pending = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            check("to_pend",  32'(cmd_pending), 32'd1);
            check("to_quiet", 32'(timeout),     32'd0);
            step();
        end
        check("to_pulse",   32'(timeout),       32'd1);
        check("to_ack",     32'(req_ack),       32'b010);
        check("to_cnt",     32'(timeout_count), 32'd1);
        check("to_pendoff", 32'(cmd_pending),   32'd0);
        step();
        check("to_pulse_off", 32'(timeout),       32'd0);
        check("to_ack_off",   32'(req_ack),       32'd0);
        check("to_cnt_hold",  32'(timeout_count), 32'd1);

        // Ack in the 8th GRANT cycle wins over the timeout.
        req_pending    = 3'b100;
        req_dat[95:64] = 32'hD00D_0002;
        step();
        req_pending = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            check("co_pend", 32'(cmd_pending), 32'd1);
            if (i == 8) cmd_ack = 1'b1;
            step();
        end
        cmd_ack = 1'b0;
        check("co_to",   32'(timeout),       32'd0);
        check("co_ack",  32'(req_ack),       32'b100);
        check("co_tcnt", 32'(timeout_count), 32'd1);
        step();
        check("co_idle", 32'(busy), 32'd0);

        // Reset two cycles into a grant of requester 2.
        req_pending = 3'b100;
        step();
        check("mid_grant", 32'(grant), 32'b100);
        step();
        rst = 1'b1;
        #1;
        check("mid_pend",  32'(cmd_pending),   32'd0);
        check("mid_dat",   cmd_dat,            32'd0);
        check("mid_grant0", 32'(grant),        32'd0);
        check("mid_ack",   32'(req_ack),       32'd0);
        check("mid_busy",  32'(busy),          32'd0);
        check("mid_to",    32'(timeout),       32'd0);
        check("mid_tcnt",  32'(timeout_count), 32'd0);
        req_pending = 3'b110;
        step();
        step();
        rst = 1'b0;
        step();
        check("rel_nogrant", 32'(grant), 32'd0);
        step();
        check("rel_grant", 32'(grant), 32'b010);
        check("rel_dat",   cmd_dat,    32'hC0DE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
